display_arbiter: RTL
====================

// Module: display_arbiter
// PURPOSE
//  Shares one 4-digit segment_display instance between 4 requesters (e.g. time, alarm, counter, message).
//  Round-robin grant, minimum hold time per grant, blank gap between owners.
//  Drives the segment_display digit/enable/dp inputs (en, bin0..bin3, dpin) from the granted requester.
//  Runs in the 1 kHz display clock domain; 1 cycle = 1 ms.
// PARAMETERS
//  HOLD_MS  1000  cycles a grant is held before a pending other requester may take over (>=1)
//  GAP_MS   50    cycles of blanked display (en=0000) between two different owners (>=1)
//  CNT_W    16    width of the shared hold/gap counter; must hold max(HOLD_MS,GAP_MS)
// PORTS
//  clk_1kHz  in   1   display clock
//  rst_      in   1   asynchronous active-low reset
//  req       in   4   request per requester i, level; held while requester wants the display
//  digits    in   64  requester i digits at [16i+15:16i]; nibble 0 (LSB) -> bin0 ... nibble 3 -> bin3
//  dps       in   16  requester i decimal points at [4i+3:4i] -> dpin
//  digen     in   16  requester i digit enables at [4i+3:4i] -> en
//  grant     out  4   one-hot owner, 0000 when none
//  busy      out  1   1 when state != IDLE
//  en        out  4   to segment_display.en
//  bin0..3   out  4   each, to segment_display.bin0..bin3
//  dpin      out  4   to segment_display.dpin
// BEHAVIOUR
//  - Clock: one clock; reset is asynchronous and active-low. All outputs registered.
//  - Reset values: grant=0000, busy=0, en=0000, bin0..3=0, dpin=0000, rr pointer=3 (req0 checked first), cnt=0.
//  - States: IDLE, HOLD, GAP.
//  - IDLE: en=0000. If req!=0: pick first set bit searching from ptr+1 mod 4 upward;
//    next cycle grant=onehot(winner), ptr=winner, cnt=0, -> HOLD. Latency req->grant = 1 cycle.
//  - HOLD: en/bin/dpin copy owner's digen/digits/dps every cycle (1-cycle register delay); cnt++ saturating at HOLD_MS.
//    - Owner drops req: if other req pending -> GAP; else -> IDLE. Release takes effect next cycle.
//    - cnt reaches HOLD_MS-1 with another req pending -> GAP. Owner still requesting, none other -> stay, cnt saturates.
//    - Arbitration re-evaluates only at those points; late arrivals wait for expiry.
//  - GAP: grant=0000, en=0000, bin/dpin hold last values; counts GAP_MS cycles, then arbitrates as IDLE
//    (winner from ptr+1; if req==0 -> IDLE). Owner returning alone after gap is regranted.
//  - Requests dropped during GAP are ignored; no grant to a requester whose req is low at the arbitration cycle.
//  - grant is always one-hot or zero; en==0000 whenever grant==0000.
//  - Reset mid-HOLD/GAP: immediate return to reset values, ptr=3.
// CONFIGURATION
//  PREEMPT_EN defined: req[0] is urgent. In HOLD (owner!=0) or GAP, a rising req[0] grants
//    requester 0 on the next cycle, skipping hold expiry and gap; ptr unchanged by a preempt grant.
//    Requester 0 then holds until it drops req[0] (no HOLD_MS expiry for owner 0), then GAP as normal.
//  PREEMPT_EN undefined: requester 0 is an ordinary round-robin participant.
// TESTING (HOLD_MS=4, GAP_MS=2 for bench)
//  1 reset, req=0001, digits[15:0]=16'h21d9, digen[3:0]=4'hF -> grant=0001 after 1 cycle; en=F, bin3..0=2,1,d,9 next cycle.
//  2 req=0011 from IDLE -> req0 owns 4 cycles; 2 cycles en=0000 grant=0; then grant=0010, ptr=1.
//  3 owner req0 drops req at cycle 2 with req=0100 pending -> GAP 2 cycles -> grant=0100.
//  4 req=1111 held -> grants rotate 0001,0010,0100,1000,0001 with 4-hold/2-gap spacing.
//  5 assert rst_=0 mid-HOLD -> grant,en,busy =0 same cycle (async); after release req=0010 -> grant=0010.
//  6 PREEMPT_EN: owner=0100 in HOLD, req[0] rises -> next cycle grant=0001, no gap; drop -> GAP -> grant=0100.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: shares one 4-digit segment_display between 4 requesters.
// Round-robin grant with a minimum hold time per owner and a blanked gap
// between two different owners. Runs in the 1 kHz display clock domain.
// Optional build macro PREEMPT_EN: req[0] becomes urgent and preempts
// HOLD/GAP on its rising edge, then holds without hold-time expiry.
module display_arbiter #(
    parameter int HOLD_MS = 1000,
    parameter int GAP_MS  = 50,
    parameter int CNT_W   = 16
) (
    input  logic        clk_1kHz,
    input  logic        rst_,
    input  logic [3:0]  req,
    input  logic [63:0] digits,
    input  logic [15:0] dps,
    input  logic [15:0] digen,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [3:0]  en,
    output logic [3:0]  bin0,
    output logic [3:0]  bin1,
    output logic [3:0]  bin2,
    output logic [3:0]  bin3,
    output logic [3:0]  dpin
);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MS - 1);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       grant_nxt;
    logic [3:0]       others;
    logic             pick_ok;
    logic [1:0]       pick_idx;
    logic             urgent;
    logic             can_expire;
    logic [15:0]      own_digits;
    logic [3:0]       own_dps;
    logic [3:0]       own_en;

    // First requester set searching upward from p+1 (mod 4); MSB flags a hit.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] c;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            c = p + 2'(k);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

`ifdef PREEMPT_EN
    logic req0_q;

    // Remember req[0] so its rising edge can be detected as an urgent request.
    always_ff @(posedge clk_1kHz or negedge rst_) begin
        if (!rst_) req0_q <= 1'b0;
        else       req0_q <= req[0];
    end

    assign urgent     = req[0] & ~req0_q;
    assign can_expire = (owner != 2'd0);
`else
    assign urgent     = 1'b0;
    assign can_expire = 1'b1;
`endif

    assign {pick_ok, pick_idx} = rr_pick(req, ptr);
    assign others     = req & ~grant;
    assign own_digits = digits[{owner, 4'b0000} +: 16];
    assign own_dps    = dps[{owner, 2'b00} +: 4];
    assign own_en     = digen[{owner, 2'b00} +: 4];

    // Next-state logic: arbitration only from IDLE, at hold expiry/release, or at gap end.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        unique case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_nxt = HOLD;
                    owner_nxt = pick_idx;
                    ptr_nxt   = pick_idx;
                    grant_nxt = 4'b0001 << pick_idx;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                cnt_nxt = (cnt >= HOLD_MAX) ? cnt : cnt + 1'b1;
                if (urgent && owner != 2'd0) begin
                    // Preempt grant: pointer deliberately left alone.
                    owner_nxt = 2'd0;
                    grant_nxt = 4'b0001;
                    cnt_nxt   = '0;
                end else if (!req[owner] || (can_expire && cnt >= HOLD_LAST && |others)) begin
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = (|others) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (urgent) begin
                    state_nxt = HOLD;
                    owner_nxt = 2'd0;
                    grant_nxt = 4'b0001;
                    cnt_nxt   = '0;
                end else if (cnt >= GAP_LAST) begin
                    cnt_nxt = '0;
                    if (pick_ok) begin
                        state_nxt = HOLD;
                        owner_nxt = pick_idx;
                        ptr_nxt   = pick_idx;
                        grant_nxt = 4'b0001 << pick_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Control registers; ptr resets to 3 so requester 0 is checked first.
    always_ff @(posedge clk_1kHz or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            ptr   <= 2'd3;
            owner <= 2'd0;
            cnt   <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            grant <= grant_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Display mux: copies the current owner one cycle late; blanks when the grant ends.
    always_ff @(posedge clk_1kHz or negedge rst_) begin
        if (!rst_) begin
            en   <= '0;
            bin0 <= '0;
            bin1 <= '0;
            bin2 <= '0;
            bin3 <= '0;
            dpin <= '0;
        end else begin
            en <= (state == HOLD && grant_nxt != 4'b0000) ? own_en : 4'b0000;
            if (state == HOLD) begin
                bin0 <= own_digits[3:0];
                bin1 <= own_digits[7:4];
                bin2 <= own_digits[11:8];
                bin3 <= own_digits[15:12];
                dpin <= own_dps;
            end
        end
    end

endmodule
